// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, response, shared-ALU and counter signals of alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_ctrl;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_ctrl;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  alucontrol;
    logic [31:0] alu_out;
    logic        zero;
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;

    // Requesters plus the shared combinational ALU
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output alu_out, zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_zero, src_a, src_b, alucontrol,
        input  gnt_cnt0, gnt_cnt1
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  alu_out, zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_zero, src_a, src_b, alucontrol,
        output gnt_cnt0, gnt_cnt1
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter in front of a shared combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    alu_arbiter_if.slave bus
);

    localparam logic C_FIXED_PRIO = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rst_q;
    logic        r_last_gnt;
    logic        r_op_id;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [2:0]  r_op_ctrl;
    logic [31:0] r_rsp_data;
    logic        r_rsp_zero;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    logic        w_can_accept;
    logic        w_win0;
    logic        w_win1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_exec;

    // Grants are suppressed in the reset cycle and the one following it
    always_comb begin
        w_can_accept = ((r_state == IDLE) || (r_state == RESP)) && !reset && !r_rst_q;
        w_win0       = bus.req0_valid && (!bus.req1_valid || C_FIXED_PRIO || r_last_gnt);
        w_win1       = bus.req1_valid && !w_win0;
        w_acc0       = w_can_accept && w_win0;
        w_acc1       = w_can_accept && w_win1;
        w_exec       = (r_state == EXEC) && !reset;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (w_acc0 || w_acc1) ? EXEC : IDLE;
            EXEC:    w_state_nxt = RESP;
            RESP:    w_state_nxt = (w_acc0 || w_acc1) ? EXEC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_rst_q <= reset;
        if (reset) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_op_id    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_ctrl  <= '0;
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc0 || w_acc1) begin
                r_op_a     <= w_acc1 ? bus.req1_a    : bus.req0_a;
                r_op_b     <= w_acc1 ? bus.req1_b    : bus.req0_b;
                r_op_ctrl  <= w_acc1 ? bus.req1_ctrl : bus.req0_ctrl;
                r_op_id    <= w_acc1;
                r_last_gnt <= w_acc1;
                if (w_acc1) begin
                    r_cnt1 <= r_cnt1 + 16'd1;
                end else begin
                    r_cnt0 <= r_cnt0 + 16'd1;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_data <= bus.alu_out;
                r_rsp_zero <= bus.zero;
            end
        end
    end

    assign bus.req0_ready = w_acc0;
    assign bus.req1_ready = w_acc1;
    assign bus.rsp0_valid = (r_state == RESP) && !reset && (r_op_id == 1'b0);
    assign bus.rsp1_valid = (r_state == RESP) && !reset && (r_op_id == 1'b1);
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.src_a      = w_exec ? r_op_a    : 32'd0;
    assign bus.src_b      = w_exec ? r_op_b    : 32'd0;
    assign bus.alucontrol = w_exec ? r_op_ctrl : 3'd0;
    assign bus.gnt_cnt0   = r_cnt0;
    assign bus.gnt_cnt1   = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed + random bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   wrap_preload = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if bus ();
    alu_arbiter_if bus_fp ();

    alu_arbiter #(.FIXED_PRIO(0)) dut    (.clk(clk), .reset(reset), .bus(bus));
    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_out    = alu_f(bus.src_a, bus.src_b, bus.alucontrol);
    assign bus.zero       = (bus.alu_out == 32'd0);
    assign bus_fp.alu_out = alu_f(bus_fp.src_a, bus_fp.src_b, bus_fp.alucontrol);
    assign bus_fp.zero    = (bus_fp.alu_out == 32'd0);

    assign bus_fp.req0_valid = bus.req0_valid;
    assign bus_fp.req0_a     = bus.req0_a;
    assign bus_fp.req0_b     = bus.req0_b;
    assign bus_fp.req0_ctrl  = bus.req0_ctrl;
    assign bus_fp.req1_valid = bus.req1_valid;
    assign bus_fp.req1_a     = bus.req1_a;
    assign bus_fp.req1_b     = bus.req1_b;
    assign bus_fp.req1_ctrl  = bus.req1_ctrl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one op occupies the arbiter for two cycles after acceptance
    int          m_free = 0;
    logic        m_last = 1'b1;
    logic [15:0] m_cnt0 = '0;
    logic [15:0] m_cnt1 = '0;
    logic [31:0] m_rsp_data = '0;
    logic        m_rsp_zero = 1'b0;
    bit          m_pend = 1'b0;
    int          m_exec_cyc = 0;
    logic        m_id = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [2:0]  m_c = '0;

    always @(negedge clk) begin : p_cmp
        int          c;
        logic        winner;
        logic        e_r0, e_r1, e_v0, e_v1;
        logic [31:0] e_sa, e_sb;
        logic [2:0]  e_ac;
        c = cyc;
        if (wrap_preload) m_cnt1 = 16'hFFFD;
        e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
        e_sa = '0;   e_sb = '0;   e_ac = '0;
        if (bus.req0_valid && bus.req1_valid) winner = ~m_last;
        else                                  winner = bus.req1_valid;
        if (!reset) begin
            if (c >= m_free && (bus.req0_valid || bus.req1_valid)) begin
                e_r0 = (winner == 1'b0);
                e_r1 = (winner == 1'b1);
            end
            if (m_pend && c == m_exec_cyc) begin
                e_sa = m_a; e_sb = m_b; e_ac = m_c;
            end
            if (m_pend && c == m_exec_cyc + 1) begin
                e_v0 = (m_id == 1'b0);
                e_v1 = (m_id == 1'b1);
            end
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
        chk("src_a", bus.src_a, e_sa);
        chk("src_b", bus.src_b, e_sb);
        chk("alucontrol", 32'(bus.alucontrol), 32'(e_ac));
        if (!reset) begin
            chk("rsp_data", bus.rsp_data, m_rsp_data);
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(m_rsp_zero));
            chk("gnt_cnt0", 32'(bus.gnt_cnt0), 32'(m_cnt0));
            chk("gnt_cnt1", 32'(bus.gnt_cnt1), 32'(m_cnt1));
        end
        if (reset) begin
            m_free = c + 2; m_pend = 1'b0; m_last = 1'b1;
            m_cnt0 = '0; m_cnt1 = '0; m_rsp_data = '0; m_rsp_zero = 1'b0;
        end else begin
            if (m_pend && c == m_exec_cyc) begin
                m_rsp_data = alu_f(m_a, m_b, m_c);
                m_rsp_zero = (m_rsp_data == 32'd0);
            end
            if (m_pend && c == m_exec_cyc + 1) m_pend = 1'b0;
            if (e_r0 || e_r1) begin
                m_pend = 1'b1; m_exec_cyc = c + 1; m_free = c + 2;
                m_id = e_r1; m_last = e_r1;
                m_a = e_r1 ? bus.req1_a : bus.req0_a;
                m_b = e_r1 ? bus.req1_b : bus.req0_b;
                m_c = e_r1 ? bus.req1_ctrl : bus.req0_ctrl;
                if (e_r1) m_cnt1 = m_cnt1 + 16'd1;
                else      m_cnt0 = m_cnt0 + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] c);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single op from requester 0
        set_req(0, 1'b1, 32'd5, 32'd3, 3'b010);
        @(negedge clk);
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 32'd99, 32'd99, 3'b111);
        @(negedge clk);
        chk("t1_src_a", bus.src_a, 32'd5);
        chk("t1_src_b", bus.src_b, 32'd3);
        chk("t1_ctrl", 32'(bus.alucontrol), 32'b010);
        tick();
        @(negedge clk);
        chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("t1_rsp_data", bus.rsp_data, 32'd8);
        chk("t1_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        chk("t1_cnt0", 32'(bus.gnt_cnt0), 32'd1);
        tick();

        // Tie: round-robin on dut, fixed priority on dut_fp
        reset_pulse();
        set_req(0, 1'b1, 32'd7, 32'd7, 3'b110);
        set_req(1, 1'b1, 32'hF0, 32'h0F, 3'b001);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("t2_ready0", 32'(bus.req0_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
                chk("t2_ready1", 32'(bus.req1_ready), (k % 4 == 2) ? 32'd1 : 32'd0);
                chk("fp_ready0", 32'(bus_fp.req0_ready), 32'd1);
            end
            chk("fp_ready1", 32'(bus_fp.req1_ready), 32'd0);
            if (k == 2) begin
                chk("t2_rsp0_data", bus.rsp_data, 32'd0);
                chk("t2_rsp0_zero", 32'(bus.rsp_zero), 32'd1);
            end
            if (k == 4) begin
                chk("t2_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
                chk("t2_rsp1_data", bus.rsp_data, 32'hFF);
                chk("t2_rsp1_zero", 32'(bus.rsp_zero), 32'd0);
            end
            if (k < 7) tick();
        end

        // Back-to-back requester 1
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 32'hFFFF0000, 32'h00FFFF00, 3'b000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("fp_cnt0", 32'(bus_fp.gnt_cnt0), 32'd4);
                chk("fp_cnt1", 32'(bus_fp.gnt_cnt1), 32'd0);
                chk("t2_cnt0", 32'(bus.gnt_cnt0), 32'd2);
                chk("t2_cnt1", 32'(bus.gnt_cnt1), 32'd2);
            end
            if (k % 2 == 0) chk("t3_ready1", 32'(bus.req1_ready), 32'd1);
            if (k >= 2 && k % 2 == 0) chk("t3_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            if (k >= 2) chk("t3_rsp_data", bus.rsp_data, 32'h00FF0000);
            if (k < 7) tick();
        end
        tick();
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) tick();

        // Reset during EXEC abandons the op
        set_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
        @(negedge clk);
        chk("t4_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_src_a_rst", bus.src_a, 32'd0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 32'd2, 32'd2, 3'b010);
        set_req(1, 1'b1, 32'd4, 32'd4, 3'b010);
        @(negedge clk);
        chk("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("t4_cnt0", 32'(bus.gnt_cnt0), 32'd0);
        chk("t4_ready0_blk", 32'(bus.req0_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_tie_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t4_tie_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) tick();

        // Counter wrap: preload near the top, then three accepts
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        force dut.r_cnt1 = 16'hFFFD;
        wrap_preload = 1'b1;
        tick();
        release dut.r_cnt1;
        wrap_preload = 1'b0;
        set_req(1, 1'b1, 32'd3, 32'd4, 3'b001);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) chk("t5_cnt1_fffe", 32'(bus.gnt_cnt1), 32'hFFFE);
            if (k == 5) begin
                chk("t5_cnt1_wrap", 32'(bus.gnt_cnt1), 32'h0000);
                chk("t5_cnt0", 32'(bus.gnt_cnt0), 32'h0000);
            end
            if (k < 5) tick();
        end
        tick();
        set_req(1, 1'b0, '0, '0, '0);
        repeat (2) tick();

        // Random traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a0, a1;
            a0 = $urandom;
            a1 = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            set_req(0, $urandom_range(0, 2) != 0, a0,
                    ($urandom_range(0, 3) == 0) ? a0 : $urandom, 3'($urandom_range(0, 7)));
            set_req(1, $urandom_range(0, 2) != 0, a1,
                    ($urandom_range(0, 3) == 0) ? a1 : $urandom, 3'($urandom_range(0, 7)));
            tick();
        end
        reset = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
